// File: rtl/stacker_pkg.sv
// Shared definitions for the stacker game: FSM state encoding, board geometry
// and the small combinational helpers used by the controller and bar mover.
package stacker_pkg;

  localparam int          NUM_ROWS = 8;
  localparam int          NUM_COLS = 8;
  localparam logic [7:0]  FULL_ROW = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_MOVE,
    ST_COMMIT,
    ST_MISS,
    ST_LOSE,
    ST_WIN
  } state_t;

  // Contiguous run of `width` lit columns starting at column `pos`.
  function automatic logic [7:0] bar_pattern(input logic [3:0] width, input logic [2:0] pos);
    logic [15:0] mask;
    mask = (16'd1 << width) - 16'd1;
    return 8'(mask << pos);
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/stacker_bar_mover.sv
// Holds the sliding bar (position, direction, width) and bounces it between the
// row edges on each step; exposes the current and post-step bar patterns.
module stacker_bar_mover
  import stacker_pkg::*;
#(
  parameter int START_WIDTH = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_width,
  input  logic       step,
  output logic [7:0] cur,
  output logic [7:0] cur_nxt
);

  logic [2:0] pos_q;
  logic [3:0] width_q;
  logic       dir_up_q;

  logic [2:0] pos_nxt;
  logic       dir_up_nxt;
  logic [3:0] right_edge;

  // Reverse on the step that would run off either edge, so the bar never
  // sits on an edge for two ticks.
  always_comb begin
    right_edge = {1'b0, pos_q} + width_q;
    dir_up_nxt = dir_up_q;
    pos_nxt    = pos_q;
    if (dir_up_q && right_edge == 4'(NUM_COLS)) begin
      dir_up_nxt = 1'b0;
      pos_nxt    = pos_q - 3'd1;
    end else if (!dir_up_q && pos_q == 3'd0) begin
      dir_up_nxt = 1'b1;
      pos_nxt    = 3'd1;
    end else if (dir_up_q) begin
      pos_nxt = pos_q + 3'd1;
    end else begin
      pos_nxt = pos_q - 3'd1;
    end
  end

  assign cur     = bar_pattern(width_q, pos_q);
  assign cur_nxt = bar_pattern(width_q, pos_nxt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q    <= 3'd0;
      width_q  <= 4'(START_WIDTH);
      dir_up_q <= 1'b1;
    end else if (load) begin
      pos_q    <= 3'd0;
      width_q  <= load_width;
      dir_up_q <= 1'b1;
    end else if (step) begin
      pos_q    <= pos_nxt;
      dir_up_q <= dir_up_nxt;
    end
  end

endmodule

// File: rtl/stacker_game_ctrl.sv
// Stacker game controller: runs the row-by-row lock/trim game and drives the
// display row writer with registered write/clear strobes, row index and score.
module stacker_game_ctrl
  import stacker_pkg::*;
#(
  parameter int START_WIDTH = 3,
  parameter int SHRINK_ROW2 = 4,
  parameter int SHRINK_ROW1 = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic       update_tick,
  output logic [7:0] val,
  output logic [2:0] row_index,
  output logic       write_strobe,
  output logic       clr_array,
  output logic       game_over,
  output logic       win,
  output logic [3:0] score
);

  localparam logic [2:0] LAST_ROW  = 3'(NUM_ROWS - 1);
  localparam logic [3:0] MAX_SCORE = 4'(NUM_ROWS);

  state_t     state_q, state_d;
  logic [7:0] prev_q;
  logic       load;
  logic [3:0] load_width;
  logic       step;
  logic [7:0] cur;
  logic [7:0] cur_nxt;
  logic [7:0] ov;
  logic [3:0] next_row;
  logic [3:0] next_width;

  function automatic logic [3:0] cap_width(input logic [3:0] pc, input logic [3:0] nrow);
    logic [3:0] w;
    w = pc;
    if (int'(nrow) >= SHRINK_ROW1 && w > 4'd1) w = 4'd1;
    else if (int'(nrow) >= SHRINK_ROW2 && w > 4'd2) w = 4'd2;
    return w;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= MAX_SCORE) ? MAX_SCORE : s + 4'd1;
  endfunction

  stacker_bar_mover #(
    .START_WIDTH(START_WIDTH)
  ) u_bar (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_width(load_width),
    .step      (step),
    .cur       (cur),
    .cur_nxt   (cur_nxt)
  );

  // prev_q already holds the locked overlap while in COMMIT.
  assign ov         = cur & prev_q;
  assign next_row   = {1'b0, row_index} + 4'd1;
  assign next_width = cap_width(popcount8(prev_q), next_row);

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    load_width = 4'(START_WIDTH);
    step       = 1'b0;
    case (state_q)
      ST_IDLE:  if (btn) state_d = ST_CLEAR;
      ST_CLEAR: begin
        load    = 1'b1;
        state_d = ST_LOAD;
      end
      ST_LOAD:  state_d = ST_MOVE;
      ST_MOVE: begin
        // A press takes priority; a coincident tick is dropped.
        if (btn) state_d = (ov == 8'h00) ? ST_MISS : ST_COMMIT;
        else if (update_tick) step = 1'b1;
      end
      ST_COMMIT: begin
        load       = 1'b1;
        load_width = next_width;
        state_d    = (row_index == LAST_ROW) ? ST_WIN : ST_LOAD;
      end
      ST_MISS:  state_d = ST_LOSE;
      ST_LOSE,
      ST_WIN:   if (btn) state_d = ST_CLEAR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // cycle spent in that state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      prev_q       <= FULL_ROW;
      val          <= 8'h00;
      row_index    <= 3'd0;
      write_strobe <= 1'b0;
      clr_array    <= 1'b0;
      game_over    <= 1'b0;
      win          <= 1'b0;
      score        <= 4'd0;
    end else begin
      state_q      <= state_d;
      clr_array    <= (state_d == ST_CLEAR);
      write_strobe <= step || (state_d == ST_LOAD) || (state_d == ST_COMMIT) ||
                      (state_d == ST_MISS);
      game_over    <= (state_d == ST_LOSE);
      win          <= (state_d == ST_WIN);
      case (state_d)
        ST_CLEAR: begin
          row_index <= 3'd0;
          score     <= 4'd0;
          prev_q    <= FULL_ROW;
        end
        ST_LOAD: begin
          val <= bar_pattern(load_width, 3'd0);
          if (state_q == ST_COMMIT) row_index <= row_index + 3'd1;
        end
        ST_MOVE:   if (step) val <= cur_nxt;
        ST_COMMIT: begin
          val    <= ov;
          prev_q <= ov;
          score  <= sat_inc(score);
        end
        ST_MISS:   val <= 8'h00;
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_stacker_game_ctrl.sv
// Scoreboard bench for stacker_game_ctrl: a game-level reference model queues
// the expected display events and a negedge monitor checks them as they appear.
module tb_stacker_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn;
  logic       update_tick;
  logic [7:0] val;
  logic [2:0] row_index;
  logic       write_strobe;
  logic       clr_array;
  logic       game_over;
  logic       win;
  logic [3:0] score;

  stacker_game_ctrl #(
    .START_WIDTH(3),
    .SHRINK_ROW2(4),
    .SHRINK_ROW1(6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .update_tick (update_tick),
    .val         (val),
    .row_index   (row_index),
    .write_strobe(write_strobe),
    .clr_array   (clr_array),
    .game_over   (game_over),
    .win         (win),
    .score       (score)
  );

  always #5 clk = ~clk;

  localparam int EV_CLR  = 0;
  localparam int EV_WR   = 1;
  localparam int EV_OVER = 2;
  localparam int EV_WIN  = 3;

  typedef struct {
    int kind;
    int row;
    int val;
    int score;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  // Reference game state: mode 0 idle, 1 playing, 2 lost, 3 won.
  int m_mode, m_row, m_score, m_prev, m_w, m_pos, m_dir;

  function automatic int bar(input int w, input int p);
    int r;
    r = 0;
    for (int c = 0; c < 8; c++) if (c >= p && c < p + w) r = r | (1 << c);
    return r;
  endfunction

  task automatic push(input int k, input int r, input int v, input int s);
    ev_t e;
    e.kind = k; e.row = r; e.val = v; e.score = s;
    exp_q.push_back(e);
  endtask

  task automatic model_start();
    m_row = 0; m_score = 0; m_prev = 255; m_w = 3; m_pos = 0; m_dir = 1; m_mode = 1;
    push(EV_CLR, 0, 0, 0);
    push(EV_WR, 0, bar(3, 0), 0);
  endtask

  task automatic model_press();
    int ov;
    if (m_mode != 1) begin
      model_start();
    end else begin
      ov = bar(m_w, m_pos) & m_prev;
      if (ov == 0) begin
        push(EV_WR, m_row, 0, m_score);
        push(EV_OVER, m_row, 0, m_score);
        m_mode = 2;
      end else begin
        m_score = (m_score < 8) ? m_score + 1 : 8;
        m_prev  = ov;
        push(EV_WR, m_row, ov, m_score);
        if (m_row == 7) begin
          push(EV_WIN, 7, 0, m_score);
          m_mode = 3;
        end else begin
          m_row = m_row + 1;
          m_w   = $countones(ov);
          if (m_row >= 6 && m_w > 1) m_w = 1;
          else if (m_row >= 4 && m_w > 2) m_w = 2;
          m_pos = 0; m_dir = 1;
          push(EV_WR, m_row, bar(m_w, 0), m_score);
        end
      end
    end
  endtask

  task automatic model_tick();
    int n;
    if (m_mode == 1) begin
      n = m_pos + m_dir;
      if (n < 0 || n + m_w > 8) begin
        m_dir = -m_dir;
        n = m_pos + m_dir;
      end
      m_pos = n;
      push(EV_WR, m_row, bar(m_w, m_pos), m_score);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic act(input bit b, input bit t);
    @(posedge clk); #1;
    btn = b; update_tick = t;
    if (b) model_press();
    else if (t) model_tick();
    @(posedge clk); #1;
    btn = 1'b0; update_tick = 1'b0;
  endtask

  task automatic press();
    act(1'b1, 1'b0);
    gap(3);
  endtask

  task automatic tick();
    act(1'b0, 1'b1);
    gap(2);
  endtask

  // Button held for three edges: accepted in MOVE, then seen in COMMIT and LOAD.
  task automatic press_hold3();
    @(posedge clk); #1;
    btn = 1'b1;
    model_press();
    repeat (3) @(posedge clk);
    #1 btn = 1'b0;
    gap(3);
  endtask

  task automatic chk(input string name, input int got, input int req);
    total++;
    if (got != req) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, int'({val, row_index, write_strobe, clr_array, game_over, win, score}), 0);
  endtask

  // Monitor: one scoreboard pop per presented event.
  logic go_prev  = 1'b0;
  logic win_prev = 1'b0;
  always @(negedge clk) begin
    int  k;
    ev_t e;
    bit  ok;
    if (reset) begin
      go_prev  = 1'b0;
      win_prev = 1'b0;
    end else begin
      k = -1;
      if (clr_array && write_strobe) begin
        total++; bad++;
        $display("FAIL clr_with_write: clr_array=1 write_strobe=1, required at most one");
      end
      if (clr_array) k = EV_CLR;
      else if (write_strobe) k = EV_WR;
      else if (game_over && !go_prev) k = EV_OVER;
      else if (win && !win_prev) k = EV_WIN;
      if (k >= 0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event: kind=%0d row=%0d val=%h score=%0d, required no event",
                   k, row_index, val, score);
        end else begin
          e  = exp_q.pop_front();
          ok = (k == e.kind) && (int'(row_index) == e.row) && (int'(score) == e.score);
          case (e.kind)
            EV_WR:   ok = ok && (int'(val) == e.val) && !game_over && !win;
            EV_CLR:  ok = ok && !game_over && !win;
            EV_OVER: ok = ok && !win;
            default: ok = ok && !game_over;
          endcase
          if (!ok)
            $display("FAIL event_%0d: got kind=%0d row=%0d val=%h score=%0d go=%0b win=%0b, required kind=%0d row=%0d val=%h score=%0d",
                     e.kind, k, row_index, val, score, game_over, win,
                     e.kind, e.row, e.val, e.score);
          if (!ok) bad++;
        end
      end
      go_prev  = game_over;
      win_prev = win;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; btn = 1'b0; update_tick = 1'b0; m_mode = 0;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset_outputs");
    reset = 1'b0;
    gap(3);
    #1 chk_all_zero("idle_quiet");

    // First game: bounce across row 0, lock at 1C, then 07 -> overlap 04, then miss.
    press();
    repeat (6) tick();
    gap(4);
    tick();
    tick();
    press();
    press();
    press();
    press();

    // Miss with prev 1C and bar at E0, a tick ignored in LOSE, then restart.
    tick(); tick(); press();
    repeat (5) tick();
    press();
    tick();
    press();

    // Coincident press and tick, then a press held across COMMIT and LOAD.
    tick();
    act(1'b1, 1'b1);
    gap(3);
    press_hold3();
    press();
    press();

    // Perfect game through row 7 with width caps, tick ignored in WIN, restart.
    press();
    repeat (8) press();
    tick();
    press();

    for (int g = 0; g < 8; g++) begin
      if (m_mode != 1) press();
      for (int k = 0; k < 60 && m_mode == 1; k++) begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) tick();
        else if (r < 8) press();
        else if (r == 8) begin
          act(1'b1, 1'b1);
          gap(3);
        end else gap(int'($urandom_range(1, 4)));
      end
      if ($urandom_range(0, 1) == 1) tick();
    end

    // Async reset in the middle of MOVE with a nonzero score on display.
    if (m_mode != 1) press();
    press();
    tick();
    gap(2);
    chk("queue_drained_before_reset", exp_q.size(), 0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1 chk_all_zero("async_reset_mid_move");
    exp_q.delete();
    m_mode = 0;
    @(posedge clk); #1 chk_all_zero("reset_held");
    reset = 1'b0;
    press();
    tick();
    press();
    gap(4);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stacker_game_ctrl.md
Name: stacker_game_ctrl

Overview:
- Game controller for the 8x8 stacker display.
- Sits upstream of the VGA block-array writer:
  - consumes the debounced button pulse and the speed-scaled update tick;
  - emits row write strobes, row values, the current row index (which the display top uses to pick the tick rate) and a clear-array pulse.
- A sliding bar bounces across the current row. The player presses to lock it, the bar is trimmed to its overlap with the row below, and play advances upward until the bar misses or the top row is reached.

Parameters:
- START_WIDTH, 3: bar width on row 0, range 1..3.
- SHRINK_ROW2, 4: from this row up, new bar width is capped at 2.
- SHRINK_ROW1, 6: from this row up, new bar width is capped at 1.

Ports:
- clk  in  1  system clock (display pixel clock domain).
- reset  in  1  asynchronous, active-high reset.
- btn  in  1  single-cycle debounced press pulse.
- update_tick  in  1  single-cycle bar-move pulse.
- val  out  8  row pattern; bit c = column c lit.
- row_index  out  3  row being written/played, 0 = bottom.
- write_strobe  out  1  one-cycle: write val into row row_index.
- clr_array  out  1  one-cycle: clear all 8 display rows.
- game_over  out  1  high while in LOSE.
- win  out  1  high while in WIN.
- score  out  4  rows successfully locked, 0..8.

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; internal pos=0, width=START_WIDTH, dir=up, prev=8'hFF.
- All outputs are registered.
- Bar pattern: cur = ((1<<width)-1) << pos, 8 bits; pos 0..7; dir up = pos increasing.
- States:
  - IDLE: outputs quiet; btn -> CLEAR.
  - CLEAR: clr_array=1 for this one cycle; row=0, score=0, prev=8'hFF, width=START_WIDTH, pos=0, dir=up -> LOAD.
  - LOAD: write_strobe=1, val=cur, row_index=row -> MOVE.
  - MOVE:
    - btn (wins over a same-cycle update_tick, tick dropped): ov = cur & prev; ov==0 -> MISS; else -> COMMIT.
    - Otherwise, update_tick:
      - dir up and pos+width==8: dir<=down, pos<=pos-1.
      - dir down and pos==0: dir<=up, pos<=pos+1.
      - else step pos by one in dir.
    - The cycle after each step: write_strobe=1, val=new cur.
    - No dwell at the edges.
  - COMMIT:
    - write_strobe=1, val=ov, row_index=row; prev<=ov; score<=score+1.
    - Next width = popcount(ov), capped by SHRINK_ROW2/SHRINK_ROW1 for row+1; pos=0, dir=up.
    - row==7 -> WIN; else row<=row+1 -> LOAD.
  - MISS: write_strobe=1, val=0, row_index=row -> LOSE.
  - LOSE: game_over=1; btn -> CLEAR.
  - WIN: win=1; btn -> CLEAR.
- btn in CLEAR, LOAD, COMMIT or MISS is ignored. update_tick outside MOVE is ignored.
- clr_array and write_strobe are never high in the same cycle.
- row_index holds its last value in LOSE/WIN; returns to 0 on CLEAR.
- score saturates at 8 and cannot wrap.
- Width is never 0 while in MOVE (guaranteed by the ov != 0 check).
- Reset asserted mid-game aborts immediately to IDLE with all outputs 0. No write is completed.

Decomposition:
- Shared package stacker_pkg:
  - state encoding (IDLE, CLEAR, LOAD, MOVE, COMMIT, MISS, LOSE, WIN);
  - constants NUM_ROWS=8, NUM_COLS=8, FULL_ROW=8'hFF.
- One natural sub-module: stacker_bar_mover. It holds pos/dir/width, applies the bounce step on update_tick and produces cur combinationally. The controller FSM loads it on CLEAR/COMMIT.

Test Plan:
- Reset, then btn: one cycle clr_array=1; next cycle write_strobe=1, row_index=0, val=8'h07. game_over=0, win=0, score=0.
- Six update_ticks on row 0: successive writes val=0E,1C,38,70,E0. The 6th tick bounces, val=70 with dir=down. No extra write without a tick.
- Lock row 0 at val=8'h1C: COMMIT write val=1C, row 0, score=1. Then LOAD write row_index=1, val=8'h07. Lock at 07: overlap 04, width 1, next LOAD val=8'h01, row 2.
- Miss: prev=8'h1C, bar at 8'hE0, btn -> write val=00 at current row, then game_over=1. btn in LOSE -> clr_array pulse and row 0 restart.
- btn and update_tick in the same cycle in MOVE: the tick is dropped and the commit uses the pre-tick pattern. btn during LOAD/COMMIT produces no state change.
- Lock perfectly through row 7: width capped to 2 at row 4 and 1 at row 6. After the row-7 commit, win=1, score=8. Async reset mid-MOVE forces all outputs to 0 in the same cycle.
